wsg_mux_sound: RTL and testbench
================================

// Module: wsg_mux_sound
// PURPOSE
//  Parametrised N-voice Namco-style wavetable sound generator. One phase adder, one multiplier
//  and one external wave-ROM port are time-shared across all voices. Replaces the fixed
//  3-voice generator that used one adder per voice. Sits between the CPU sound-register
//  write bus and the board mixer. Adds per-voice mute and a saturating mix. Emits a
//  sample strobe for downstream PCM mixing.
// PARAMETERS
//  NVOICE     3    number of voices (1..8)
//  FREQ_W     20   phase accumulator / frequency width (<=20, written as 5 nibbles)
//  WSEL_W     3    wave-select width; wave ROM address = {wsel, phase[FREQ_W-1 -: 5]}
//  VOL_W      4    volume width
//  SMP_W      4    wave-ROM data width
//  OUT_W      8    mixed output width
//  MIX_SHIFT  4    right shift applied to voice-product sum before saturation
//  TICK_DIV   128  CLK cycles per output sample; must be >= 2*NVOICE+3
// PORTS
//  CLK         in   1               system clock
//  RST_N       in   1               asynchronous reset, active low
//  AD          in   $clog2(NVOICE)+3 register address {voice, offset}
//  DI          in   4               register write data
//  WR          in   1               write strobe, sampled on CLK
//  WROM_A      out  WSEL_W+5        wave-ROM address
//  WROM_D      in   SMP_W           wave-ROM data, valid 1 CLK after WROM_A (synchronous ROM)
//  SND         out  OUT_W           mixed sample, unsigned
//  SAMPLE_STB  out  1               1-cycle pulse when SND updates
// BEHAVIOUR
//  Reset (async, RST_N=0): all regs, phases, prescaler, accumulator = 0; state IDLE;
//   SND=0, SAMPLE_STB=0, WROM_A=0. Reset mid-sequence aborts the sample; no strobe.
//  Register map, per voice v at {v,off}:
//   off0..4 = freq nibbles 0..4 (bits >= FREQ_W dropped); off5 = volume; off6 = wave select;
//   off7 bit0 = mute. Other DI bits are ignored.
//  Addresses with voice >= NVOICE are ignored. A write takes effect on the WR clock edge.
//  Prescaler counts 0..TICK_DIV-1 and wraps. The cycle at TICK_DIV-1 is the tick.
//  FSM IDLE -> ADDR -> DATA -> (ADDR for next voice | DONE) -> IDLE:
//   IDLE: on tick, clear accumulator, set voice index i=0, go to ADDR.
//   ADDR: WROM_A = {wsel[i], phase[i][FREQ_W-1 -: 5]} (pre-update phase).
//   DATA: prod = WROM_D * vol[i] (SMP_W+VOL_W bits).
//    If mute[i]=0, acc += prod; mute forces a 0 contribution.
//    phase[i] <= phase[i] + freq[i] mod 2^FREQ_W. The phase advances even when muted or vol=0.
//    If i==NVOICE-1 go to DONE, else i++ and go to ADDR.
//   DONE: SND <= min(acc >> MIX_SHIFT, 2^OUT_W-1); SAMPLE_STB=1 for this one edge; go to IDLE.
//  Latency: new SND and SAMPLE_STB are visible 2*NVOICE+2 cycles after the tick cycle.
//   Strobe period is exactly TICK_DIV cycles.
//  Accumulator width: SMP_W+VOL_W+$clog2(NVOICE+1). It never overflows.
//  Write to voice i while it is in ADDR/DATA: the value before the edge is used this sample.
//   The new value applies from the next sample.
//  Tick arriving while not IDLE is impossible given the TICK_DIV rule; simulation assertion flags it.
//  WROM_A holds its last value outside ADDR.
// STRUCTURE
//  Package wsg_pkg: register offset localparams (OFF_F0..OFF_F4, OFF_VOL, OFF_WSEL, OFF_CTL),
//   FSM state enum {IDLE, ADDR, DATA, DONE}.
//  Sub-module wsg_regfile: per-voice freq/vol/wsel/mute storage, write decode, indexed read port.
//  Top level holds the prescaler, FSM, phase array, multiply-accumulate and output saturation.
// TESTING (ROM model: WROM_D = WROM_A[3:0], 1-cycle latency)
//  1. Reset, release, no writes -> SND=0.
//     First SAMPLE_STB at cycle TICK_DIV-1+2*NVOICE+2; after that, every TICK_DIV cycles.
//  2. v0: freq=0x08000, vol=15, wsel=2 -> WROM_A = 0x40,0x41,... on successive samples.
//     SND = (k*15)>>4 for index k, i.e. 0,0,1,2,3,4,5,6,7,8,9,10,11,12,13,14.
//  3. v0 as in 2, mute=1 for 4 samples, then mute=0 -> SND=0 while muted.
//     On unmute, the first WROM_A is 0x40+4 beyond the pre-mute index (phase kept advancing).
//  4. ROM forced to 15, all voices vol=15: NVOICE=3 -> SND=42.
//     NVOICE=8, MIX_SHIFT=2 -> 1800>>2=450, saturates to SND=255.
//  5. v1 freq=0xF8000 -> wave index decrements by 1 per sample, wrapping 0 -> 31.
//     v1 writes beyond FREQ_W bits have no effect.
//  6. Write v0 vol during v0 DATA -> that sample uses the old vol, next sample the new vol.
//     RST_N pulse mid-DATA -> SND=0 immediately, no strobe, normal restart.

Source files
------------

// File: rtl/wsg_pkg.sv
// Shared definitions for the time-multiplexed wavetable sound generator:
// per-voice register offsets and the sequencer state encoding.
package wsg_pkg;

    localparam logic [2:0] OFF_F0   = 3'd0;
    localparam logic [2:0] OFF_F1   = 3'd1;
    localparam logic [2:0] OFF_F2   = 3'd2;
    localparam logic [2:0] OFF_F3   = 3'd3;
    localparam logic [2:0] OFF_F4   = 3'd4;
    localparam logic [2:0] OFF_VOL  = 3'd5;
    localparam logic [2:0] OFF_WSEL = 3'd6;
    localparam logic [2:0] OFF_CTL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } wsg_state_e;

endpackage

// File: rtl/wsg_regfile.sv
// Per-voice sound registers (frequency, volume, wave select, mute) written over the
// CPU nibble bus, with one indexed read port for the time-shared voice datapath.
module wsg_regfile
    import wsg_pkg::*;
#(
    parameter int NVOICE = 3,
    parameter int FREQ_W = 20,
    parameter int WSEL_W = 3,
    parameter int VOL_W  = 4,
    localparam int AD_W   = $clog2(NVOICE) + 3,
    localparam int VIDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AD_W-1:0]   ad,
    input  logic [3:0]        di,
    input  logic              wr,
    input  logic [VIDX_W-1:0] rd_idx,
    output logic [FREQ_W-1:0] rd_freq,
    output logic [VOL_W-1:0]  rd_vol,
    output logic [WSEL_W-1:0] rd_wsel,
    output logic              rd_mute
);

    logic [FREQ_W-1:0] freq_q [NVOICE];
    logic [VOL_W-1:0]  vol_q  [NVOICE];
    logic [WSEL_W-1:0] wsel_q [NVOICE];
    logic              mute_q [NVOICE];

    logic [AD_W-1:0]   wv_wide;
    logic [VIDX_W-1:0] wv;
    logic [2:0]        off;
    logic              wr_ok;
    logic [19:0]       f_mask, f_nib, f_new;

    assign wv_wide = ad >> 3;
    assign wv      = wv_wide[VIDX_W-1:0];
    assign off     = ad[2:0];
    assign wr_ok   = wr && (wv_wide < AD_W'(NVOICE));

    // Frequency is written as a 20-bit nibble image; bits at or above FREQ_W fall away.
    always_comb begin
        f_mask = 20'hF << {off, 2'b00};
        f_nib  = 20'(di) << {off, 2'b00};
        f_new  = (20'(freq_q[wv]) & ~f_mask) | f_nib;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-voice arrays are a handful of flops, not a RAM macro, so they take the async reset.
            for (int v = 0; v < NVOICE; v++) begin
                freq_q[v] <= '0;
                vol_q[v]  <= '0;
                wsel_q[v] <= '0;
                mute_q[v] <= 1'b0;
            end
        end else if (wr_ok) begin
            case (off)
                OFF_F0, OFF_F1, OFF_F2, OFF_F3, OFF_F4: freq_q[wv] <= FREQ_W'(f_new);
                OFF_VOL:  vol_q[wv]  <= VOL_W'(di);
                OFF_WSEL: wsel_q[wv] <= WSEL_W'(di);
                OFF_CTL:  mute_q[wv] <= di[0];
                default:  ;
            endcase
        end
    end

    assign rd_freq = freq_q[rd_idx];
    assign rd_vol  = vol_q[rd_idx];
    assign rd_wsel = wsel_q[rd_idx];
    assign rd_mute = mute_q[rd_idx];

endmodule

// File: rtl/wsg_mux_sound.sv
// N-voice wavetable sound generator: one phase adder, multiplier and wave-ROM port are
// shared across voices, two clocks per voice, once per prescaler tick.
module wsg_mux_sound
    import wsg_pkg::*;
#(
    parameter int NVOICE    = 3,
    parameter int FREQ_W    = 20,
    parameter int WSEL_W    = 3,
    parameter int VOL_W     = 4,
    parameter int SMP_W     = 4,
    parameter int OUT_W     = 8,
    parameter int MIX_SHIFT = 4,
    parameter int TICK_DIV  = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NVOICE)+2:0]   ad,
    input  logic [3:0]                  di,
    input  logic                        wr,
    output logic [WSEL_W+4:0]           wrom_a,
    input  logic [SMP_W-1:0]            wrom_d,
    output logic [OUT_W-1:0]            snd,
    output logic                        sample_stb
);

    localparam int VIDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam int PROD_W = SMP_W + VOL_W;
    localparam int ACC_W  = PROD_W + $clog2(NVOICE + 1);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int PRE_W  = $clog2(TICK_DIV);

    wsg_state_e        state_q, state_d;
    logic [PRE_W-1:0]  presc_q;
    logic              tick;
    logic [VIDX_W-1:0] vidx_q;
    logic              last_voice;
    logic [FREQ_W-1:0] phase_q [NVOICE];
    logic [ACC_W-1:0]  acc_q;
    logic [WSEL_W+4:0] wrom_a_q, rom_addr;
    logic [PROD_W-1:0] prod;
    logic [EXT_W-1:0]  acc_ext;
    logic [OUT_W-1:0]  snd_sat;

    logic [FREQ_W-1:0] rd_freq;
    logic [VOL_W-1:0]  rd_vol;
    logic [WSEL_W-1:0] rd_wsel;
    logic              rd_mute;

    wsg_regfile #(
        .NVOICE (NVOICE),
        .FREQ_W (FREQ_W),
        .WSEL_W (WSEL_W),
        .VOL_W  (VOL_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ad      (ad),
        .di      (di),
        .wr      (wr),
        .rd_idx  (vidx_q),
        .rd_freq (rd_freq),
        .rd_vol  (rd_vol),
        .rd_wsel (rd_wsel),
        .rd_mute (rd_mute)
    );

    assign tick       = (presc_q == PRE_W'(TICK_DIV - 1));
    assign last_voice = (vidx_q == VIDX_W'(NVOICE - 1));
    assign rom_addr   = {rd_wsel, phase_q[vidx_q][FREQ_W-1 -: 5]};
    assign wrom_a     = (state_q == ADDR) ? rom_addr : wrom_a_q;
    assign prod       = PROD_W'(wrom_d) * PROD_W'(rd_vol);
    assign acc_ext    = EXT_W'(acc_q >> MIX_SHIFT);
    assign snd_sat    = (acc_ext > EXT_W'({OUT_W{1'b1}})) ? '1 : OUT_W'(acc_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: next state defaults to the current state before the case, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = last_voice ? DONE : ADDR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vidx_q     <= '0;
            acc_q      <= '0;
            wrom_a_q   <= '0;
            snd        <= '0;
            sample_stb <= 1'b0;
            for (int v = 0; v < NVOICE; v++) phase_q[v] <= '0;
        end else begin
            // NOTE: non-blocking updates, so DATA reads the pre-edge phase and accumulator.
            sample_stb <= 1'b0;
            case (state_q)
                IDLE: if (tick) begin
                    acc_q  <= '0;
                    vidx_q <= '0;
                end
                ADDR: wrom_a_q <= rom_addr;
                DATA: begin
                    // Muted voices still advance so they resume in phase.
                    if (!rd_mute) acc_q <= acc_q + ACC_W'(prod);
                    phase_q[vidx_q] <= phase_q[vidx_q] + rd_freq;
                    if (!last_voice) vidx_q <= vidx_q + VIDX_W'(1);
                end
                DONE: begin
                    snd        <= snd_sat;
                    sample_stb <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    tick_only_when_idle: assert property (@(posedge clk) disable iff (!rst_n) tick |-> state_q == IDLE)
        else $error("prescaler tick while voice sequence still running");

endmodule

// File: tb/tb_wsg_mux_sound.sv
// Scoreboard bench: stimulus predicts each sample from a per-voice arithmetic model and
// queues expected ROM addresses and SND; a monitor pops and compares as the DUT presents them.
module tb_wsg_mux_sound;

    localparam int NV   = 5;
    localparam int FW   = 18;
    localparam int WS   = 3;
    localparam int VW   = 4;
    localparam int SW   = 4;
    localparam int OW   = 8;
    localparam int MS   = 2;
    localparam int TD   = 64;
    localparam int AD_W = $clog2(NV) + 3;

    logic             clk, rst_n, wr;
    logic [AD_W-1:0]  ad;
    logic [3:0]       di;
    logic [WS+4:0]    wrom_a;
    logic [SW-1:0]    wrom_d;
    logic [OW-1:0]    snd;
    logic             sample_stb;

    wsg_mux_sound #(
        .NVOICE(NV), .FREQ_W(FW), .WSEL_W(WS), .VOL_W(VW), .SMP_W(SW),
        .OUT_W(OW), .MIX_SHIFT(MS), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ad(ad), .di(di), .wr(wr),
        .wrom_a(wrom_a), .wrom_d(wrom_d), .snd(snd), .sample_stb(sample_stb)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;
    int last_stb = -1;
    int snd_q[$];
    int addr_q[$];

    int         rom_mode;
    logic [3:0] rom_tab [2**(WS+5)];

    int m_freq[NV], m_vol[NV], m_wsel[NV], m_mute[NV], m_phase[NV];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int rom_val(input int a);
        case (rom_mode)
            0:       return a % 16;
            1:       return 15;
            default: return int'(rom_tab[a]);
        endcase
    endfunction

    always @(posedge clk) wrom_d <= 4'(rom_val(int'(wrom_a)));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_stb = -1;
        end else begin
            if (cyc >= TD && (cyc % TD) < 2 * NV && (cyc % TD) % 2 == 0) begin
                if (addr_q.size() == 0) flag_fail("wrom_a without expectation");
                else check("wrom_a", int'(wrom_a), addr_q.pop_front());
            end
            if (sample_stb) begin
                check("stb_cycle", cyc, (last_stb < 0) ? TD - 1 + 2 * NV + 2 : last_stb + TD);
                last_stb = cyc;
                if (snd_q.size() == 0) flag_fail("unexpected sample_stb");
                else check("snd", int'(snd), snd_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = 0; m_vol[v] = 0; m_wsel[v] = 0; m_mute[v] = 0; m_phase[v] = 0;
        end
    endtask

    // One sample: every voice reads its wave at the current phase, then steps.
    task automatic predict();
        int sum = 0;
        for (int v = 0; v < NV; v++) begin
            int a = m_wsel[v] * 32 + m_phase[v] / (2 ** (FW - 5));
            addr_q.push_back(a);
            if (m_mute[v] == 0) sum += rom_val(a) * m_vol[v];
            m_phase[v] = (m_phase[v] + m_freq[v]) % (2 ** FW);
        end
        sum = sum / (2 ** MS);
        snd_q.push_back((sum > 2 ** OW - 1) ? 2 ** OW - 1 : sum);
    endtask

    task automatic reg_write(input int v, input int off, input int d);
        ad = AD_W'(v * 8 + off);
        di = 4'(d);
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        if (v < NV) begin
            if (off <= 4) begin
                int sh = 2 ** (4 * off);
                m_freq[v] = (m_freq[v] - ((m_freq[v] / sh) % 16) * sh + d * sh) % (2 ** FW);
            end else if (off == 5) m_vol[v]  = d;
            else if (off == 6)     m_wsel[v] = d % (2 ** WS);
            else                   m_mute[v] = d % 2;
        end
    endtask

    task automatic wait_strobe();
        bit seen = 0;
        for (int k = 0; k < 3 * TD && !seen; k++) begin
            @(negedge clk);
            if (sample_stb) seen = 1;
        end
        if (!seen) flag_fail("sample_stb timeout");
    endtask

    task automatic wait_mod(input int m);
        bit hit = 0;
        for (int k = 0; k < 3 * TD && !hit; k++) begin
            @(negedge clk);
            if (cyc >= TD && cyc % TD == m) hit = 1;
        end
        if (!hit) flag_fail("sequence phase timeout");
    endtask

    task automatic samples(input int n);
        repeat (n) begin
            wait_strobe();
            predict();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_snd"}, int'(snd), 0);
        check({tag, "_stb"}, int'(sample_stb), 0);
        check({tag, "_wrom_a"}, int'(wrom_a), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wr = 1'b0; ad = '0; di = '0; rom_mode = 0;
        for (int i = 0; i < 2 ** (WS + 5); i++) rom_tab[i] = 4'($urandom_range(0, 15));
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        predict();

        // Idle after reset: silent samples on the nominal strobe grid.
        samples(3);

        // Rising wave index, one step per sample, wave select 2.
        wait_strobe();
        reg_write(0, 3, 4'h2);
        reg_write(0, 5, 15);
        reg_write(0, 6, 2);
        predict();
        samples(17);

        // Mute for four samples; phase keeps advancing underneath.
        wait_strobe();
        reg_write(0, 7, 1);
        predict();
        samples(3);
        wait_strobe();
        reg_write(0, 7, 4'hE);
        predict();
        samples(3);

        // Full-scale ROM on every voice drives the mix into saturation.
        wait_strobe();
        rom_mode = 1;
        for (int v = 0; v < NV; v++) begin
            reg_write(v, 5, 15);
            reg_write(v, 7, 0);
        end
        predict();
        samples(2);

        // Falling index on voice 1; top nibble bits beyond FW drop; writes past NV ignored.
        wait_strobe();
        rom_mode = 2;
        reg_write(1, 3, 4'hE);
        reg_write(1, 4, 4'hF);
        reg_write(1, 6, 5);
        reg_write(NV, 5, 3);
        reg_write(7, 7, 1);
        predict();
        samples(34);

        // Volume write landing on voice 0's DATA cycle only counts from the next sample.
        wait_strobe();
        predict();
        wait_mod(1);
        reg_write(0, 5, 7);
        samples(2);

        // Reset pulse during voice 0's DATA cycle: immediate clear, aborted sample, clean restart.
        wait_strobe();
        predict();
        wait_mod(1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        snd_q.delete();
        addr_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        predict();
        samples(1);

        // Randomized register traffic between samples.
        wait_strobe();
        for (int v = 0; v < NV; v++) begin
            reg_write(v, $urandom_range(0, 4), $urandom_range(0, 15));
            reg_write(v, 5, $urandom_range(0, 15));
        end
        predict();
        repeat (30) begin
            wait_strobe();
            repeat ($urandom_range(0, 5)) reg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
            predict();
        end

        wait_strobe();
        @(negedge clk);
        check("snd_queue_drained", snd_q.size(), 0);
        check("addr_queue_drained", addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
